// File: rtl/delay_ctrl_pkg.sv
// Shared constants, state encoding and channel map for the delay load path.
// Optional readback checking is enabled with DLY_READBACK_EN.
package delay_ctrl_pkg;

  localparam int NCH_DEF       = 9;
  localparam int TAP_W_DEF     = 5;
  localparam int SETTLE_DEF    = 16;
  localparam int MAX_RETRY_DEF = 2;
  localparam int IDX_W         = 4;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ARB    = 3'd1;
  localparam logic [2:0] ST_LOAD   = 3'd2;
  localparam logic [2:0] ST_SETTLE = 3'd3;
  localparam logic [2:0] ST_CHECK  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_ARB    = ST_ARB,
    S_LOAD   = ST_LOAD,
    S_SETTLE = ST_SETTLE,
    S_CHECK  = ST_CHECK
  } state_e;

  localparam int R_WHOLE = 0;
  localparam int G_WHOLE = 1;
  localparam int B_WHOLE = 2;
  localparam int R_RISE  = 3;
  localparam int G_RISE  = 4;
  localparam int B_RISE  = 5;
  localparam int R_FALL  = 6;
  localparam int G_FALL  = 7;
  localparam int B_FALL  = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first pending index after the pointer.
// Used by delay_load_sequencer (DLY_READBACK_EN independent).
module rr_arbiter
  import delay_ctrl_pkg::*;
#(
  parameter int NCH = NCH_DEF
) (
  input  logic [NCH-1:0]   i_pending,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [NCH-1:0]   o_gnt,
  output logic [IDX_W-1:0] o_idx
);

  logic             w_found;
  logic [IDX_W-1:0] w_c;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_c     = '0;
    for (int k = 1; k <= NCH; k++) begin
      w_c = IDX_W'((int'(i_ptr) + k) % NCH);
      if (!w_found && i_pending[w_c]) begin
        w_found    = 1'b1;
        o_gnt[w_c] = 1'b1;
        o_idx      = w_c;
      end
    end
  end

endmodule

// File: rtl/delay_load_sequencer.sv
// Queues per-channel delay updates and serialises them onto one load port.
// Define DLY_READBACK_EN to add rb_tap verification with retry and err flags.
module delay_load_sequencer
  import delay_ctrl_pkg::*;
#(
  parameter int NCH        = NCH_DEF,
  parameter int TAP_W      = TAP_W_DEF,
  parameter int SETTLE_CYC = SETTLE_DEF
`ifdef DLY_READBACK_EN
  ,
  parameter int MAX_RETRY  = MAX_RETRY_DEF
`endif
) (
  input  logic                 clk_x10,
  input  logic                 g_rst_n,
  input  logic [NCH-1:0]       req_valid,
  input  logic [NCH*TAP_W-1:0] req_value,
  output logic                 ld_valid,
  input  logic                 ld_ready,
  output logic [IDX_W-1:0]     ld_sel,
  output logic [TAP_W-1:0]     ld_tap,
  output logic                 busy,
  output logic [NCH-1:0]       pending,
  output logic [NCH-1:0]       err
`ifdef DLY_READBACK_EN
  ,
  input  logic [TAP_W-1:0]     rb_tap
`endif
);

  localparam int CNT_W = $clog2(SETTLE_CYC + 1);

  state_e           r_state;
  state_e           w_nxt;
  logic [NCH-1:0]   r_pending;
  logic [TAP_W-1:0] r_shadow [NCH];
  logic [IDX_W-1:0] r_sel;
  logic [TAP_W-1:0] r_tap;
  logic [IDX_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_redo;
  logic [NCH-1:0]   w_gnt;
  logic [IDX_W-1:0] w_idx;
  logic             w_hs;
  logic             w_cnt_done;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .i_pending (r_pending),
    .i_ptr     (r_ptr),
    .o_gnt     (w_gnt),
    .o_idx     (w_idx)
  );

  assign w_hs       = (r_state == S_LOAD) && ld_ready;
  assign w_cnt_done = (r_state == S_SETTLE) &&
                      (r_cnt == CNT_W'(SETTLE_CYC - 1));

  assign ld_valid = (r_state == S_LOAD);
  assign busy     = (r_state != S_IDLE);
  assign ld_sel   = r_sel;
  assign ld_tap   = r_tap;
  assign pending  = r_pending;

`ifdef DLY_READBACK_EN
  localparam int RT_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  logic [RT_W-1:0] r_retry;
  logic [NCH-1:0]  r_err;
  logic            w_match;
  logic            w_retry_done;

  assign w_match      = (rb_tap == r_tap);
  assign w_retry_done = (r_retry == RT_W'(MAX_RETRY));
  assign err          = r_err;

  always_ff @(posedge clk_x10 or negedge g_rst_n) begin
    if (!g_rst_n) begin
      r_retry <= '0;
      r_err   <= '0;
    end else if (r_state == S_ARB) begin
      r_retry <= '0;
    end else if (r_state == S_CHECK && !w_match) begin
      if (w_retry_done) r_err[r_sel] <= 1'b1;
      else r_retry <= r_retry + 1'b1;
    end
  end
`else
  assign err = '0;
`endif

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE:   if (|r_pending) w_nxt = S_ARB;
      S_ARB:    w_nxt = S_LOAD;
      S_LOAD:   if (ld_ready) w_nxt = S_SETTLE;
`ifdef DLY_READBACK_EN
      S_SETTLE: if (w_cnt_done) w_nxt = S_CHECK;
      S_CHECK: begin
        if (w_match || w_retry_done) w_nxt = S_IDLE;
        else w_nxt = S_LOAD;
      end
`else
      S_SETTLE: if (w_cnt_done) w_nxt = S_IDLE;
`endif
      default:  w_nxt = S_IDLE;
    endcase
  end

  // r_redo remembers a newer value arrived for the granted channel
  always_ff @(posedge clk_x10 or negedge g_rst_n) begin
    if (!g_rst_n) begin
      r_state   <= S_IDLE;
      r_pending <= '0;
      for (int i = 0; i < NCH; i++) r_shadow[i] <= '0;
      r_sel     <= '0;
      r_tap     <= '0;
      r_ptr     <= IDX_W'(NCH - 1);
      r_cnt     <= '0;
      r_redo    <= 1'b0;
    end else begin
      r_state <= w_nxt;
      for (int i = 0; i < NCH; i++) begin
        if (req_valid[i]) begin
          r_pending[i] <= 1'b1;
          r_shadow[i]  <= req_value[i*TAP_W +: TAP_W];
        end
      end
      if (w_hs && !r_redo && !req_valid[r_sel])
        r_pending[r_sel] <= 1'b0;
      if (r_state == S_ARB) begin
        r_sel  <= w_idx;
        r_tap  <= r_shadow[w_idx];
        r_ptr  <= w_idx;
        r_redo <= |(req_valid & w_gnt);
      end else if (busy && req_valid[r_sel]) begin
        r_redo <= 1'b1;
      end
      if (w_hs) r_cnt <= '0;
      else if (r_state == S_SETTLE) r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_delay_load_sequencer.sv
// Scoreboard bench for delay_load_sequencer; readback case with DLY_READBACK_EN.
module tb_delay_load_sequencer;
  import delay_ctrl_pkg::*;

  localparam int NCH   = 9;
  localparam int TAP_W = 5;
  localparam int SC    = 16;

  logic                 clk_x10 = 1'b0;
  logic                 g_rst_n = 1'b0;
  logic [NCH-1:0]       req_valid = '0;
  logic [NCH*TAP_W-1:0] req_value = '0;
  logic                 ld_ready = 1'b1;
  logic                 ld_valid;
  logic [IDX_W-1:0]     ld_sel;
  logic [TAP_W-1:0]     ld_tap;
  logic                 busy;
  logic [NCH-1:0]       pending;
  logic [NCH-1:0]       err;
`ifdef DLY_READBACK_EN
  logic                 rb_bad = 1'b0;
  logic [TAP_W-1:0]     rb_tap;
  assign rb_tap = rb_bad ? '0 : ld_tap;
`endif

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  logic [8:0] sb [$];
  int hs_cyc [$];
  logic [8:0] e_sb;
  logic p_hold = 1'b0;
  logic [IDX_W-1:0] p_sel;
  logic [TAP_W-1:0] p_tap;

  delay_load_sequencer dut (
    .clk_x10   (clk_x10),
    .g_rst_n   (g_rst_n),
    .req_valid (req_valid),
    .req_value (req_value),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_sel    (ld_sel),
    .ld_tap    (ld_tap),
    .busy      (busy),
    .pending   (pending),
    .err       (err)
`ifdef DLY_READBACK_EN
    ,
    .rb_tap    (rb_tap)
`endif
  );

  always #5 clk_x10 = ~clk_x10;
  always @(posedge clk_x10) cyc <= cyc + 1;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_x10);
    #1;
    req_valid = '0;
  endtask

  task automatic req(int ch, int val, bit push);
    req_valid[ch] = 1'b1;
    req_value[ch*TAP_W +: TAP_W] = TAP_W'(val);
    if (push) sb.push_back({4'(ch), 5'(val)});
  endtask

  task automatic do_reset();
    g_rst_n   = 1'b0;
    req_valid = '0;
    ld_ready  = 1'b1;
    repeat (3) @(posedge clk_x10);
    #1;
    sb.delete();
    hs_cyc.delete();
    g_rst_n = 1'b1;
  endtask

  task automatic wait_ld(string tag);
    int k = 0;
    while (k < 20 && !ld_valid) begin
      tick();
      k++;
    end
    check({"ldv_", tag}, ld_valid, 1);
  endtask

  task automatic wait_idle(string tag);
    int k = 0;
    while (k < 3000 &&
           !(sb.size() == 0 && !busy && pending == '0)) begin
      tick();
      k++;
    end
    check({"idle_", tag},
          sb.size() == 0 && !busy && pending == '0, 1);
  endtask

  // handshake monitor: pops scoreboard, checks LOAD hold
  always @(negedge clk_x10) begin
    if (!g_rst_n) begin
      p_hold = 1'b0;
    end else begin
      if (p_hold)
        check("hold", {ld_valid, ld_sel, ld_tap},
              {1'b1, p_sel, p_tap});
      if (ld_valid && ld_ready) begin
        check("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e_sb = sb.pop_front();
          check("ld_sel", ld_sel, e_sb[8:5]);
          check("ld_tap", ld_tap, e_sb[4:0]);
        end
        hs_cyc.push_back(cyc);
      end
      p_hold = ld_valid && !ld_ready;
      p_sel  = ld_sel;
      p_tap  = ld_tap;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int bad;
    int nb;
    do_reset();
    check("rst_ldv", ld_valid, 0);
    check("rst_sel", ld_sel, 0);
    check("rst_tap", ld_tap, 0);
    check("rst_busy", busy, 0);
    check("rst_pend", pending, 0);
    check("rst_err", err, 0);

    // T1: single request latency and settle window
    req(4, 13, 1);
    tick();
    check("t1_pend", pending, 9'h010);
    check("t1_ldv1", ld_valid, 0);
    tick();
    check("t1_arb_busy", busy, 1);
    check("t1_ldv2", ld_valid, 0);
    tick();
    check("t1_ldv3", ld_valid, 1);
    check("t1_sel", ld_sel, 4);
    check("t1_tap", ld_tap, 13);
    nb = 0;
    while (busy && nb < 100) begin
      nb++;
      tick();
    end
    check("t1_busy_len", nb, 1 + SC);
    check("t1_pend0", pending, 0);

    // T2: all channels at once, round-robin from 0
    do_reset();
    for (int i = 0; i < NCH; i++) req(i, i, 1);
    tick();
    check("t2_pend", pending, 9'h1FF);
    wait_idle("t2");
    check("t2_hs", hs_cyc.size(), 9);
    for (int i = 1; i < hs_cyc.size(); i++)
      check("t2_gap", hs_cyc[i] - hs_cyc[i-1], SC + 3);

    // T3: ld_ready held low for 50 cycles
    ld_ready = 1'b0;
    req(1, 21, 1);
    tick();
    wait_ld("t3");
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (!(ld_valid && ld_sel == 1 && ld_tap == 21)) bad++;
      tick();
    end
    check("t3_stable", bad, 0);
    ld_ready = 1'b1;
    tick();
    check("t3_done", ld_valid, 0);
    wait_idle("t3");

    // T4: new value on ch2 in its handshake cycle
    ld_ready = 1'b0;
    req(2, 3, 1);
    tick();
    wait_ld("t4");
    check("t4_old", ld_tap, 3);
    ld_ready = 1'b1;
    req(2, 7, 1);
    tick();
    check("t4_pend", pending[2], 1);
    wait_idle("t4");

    // T5: async reset mid-settle with ch5/ch7 queued
    do_reset();
    req(0, 1, 1);
    tick();
    wait_ld("t5");
    tick();
    req(5, 10, 0);
    req(7, 11, 0);
    tick();
    check("t5_pend", pending, 9'h0A0);
    check("t5_busy", busy, 1);
    repeat (3) tick();
    #2;
    g_rst_n = 1'b0;
    #1;
    check("t5_ldv", ld_valid, 0);
    check("t5_busy0", busy, 0);
    check("t5_pend0", pending, 0);
    check("t5_sel", ld_sel, 0);
    check("t5_tap", ld_tap, 0);
    check("t5_err", err, 0);
    sb.delete();
    repeat (2) tick();
    g_rst_n = 1'b1;
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      if (ld_valid || busy) nb++;
      tick();
    end
    check("t5_noload", nb, 0);

`ifdef DLY_READBACK_EN
    // T6: readback stuck at 0 on ch6, then ch7 still served
    do_reset();
    rb_bad = 1'b1;
    req(6, 9, 1);
    sb.push_back({4'd6, 5'd9});
    sb.push_back({4'd6, 5'd9});
    tick();
    nb = 0;
    while (!err[6] && nb < 300) begin
      nb++;
      tick();
    end
    check("t6_err", err, 9'h040);
    check("t6_tries", hs_cyc.size(), 3);
    wait_idle("t6a");
    rb_bad = 1'b0;
    req(7, 4, 1);
    tick();
    wait_idle("t6b");
    check("t6_err_keep", err, 9'h040);
    check("t6_hs", hs_cyc.size(), 4);
`endif

    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
